// File: rtl/xadac_pkg.sv
// Shared types and default decode table for the XADAC execution-stage dispatcher.
// Types only; no logic, so there is no latency and no backpressure.
package xadac_pkg;

   typedef logic [31:0] InstrT;
   typedef logic [3:0]  IdT;
   typedef logic [31:0] XlenT;
   typedef logic [63:0] VectorT;

   typedef struct packed {
      IdT     id;
      InstrT  instr;
      XlenT   rs1;
      XlenT   rs2;
      VectorT vs1;
      VectorT vs2;
      VectorT vs3;
   } ex_req_t;

   typedef struct packed {
      logic rs1_read;
      logic rs2_read;
      logic vs1_read;
      logic vs2_read;
      logic vs3_read;
      logic rd_clobber;
      logic vd_clobber;
      logic accept;
   } ex_info_t;

   typedef struct packed {
      IdT     id;
      XlenT   rd;
      VectorT vd;
      logic   rd_write;
      logic   vd_write;
   } ex_resp_t;

   typedef struct packed {
      InstrT mask;
      InstrT match;
   } dec_row_t;

   localparam int unsigned DefNoUnits = 4;
   localparam InstrT DefDecMask  [DefNoUnits] = '{32'h0000_707f, 32'h01f0_707f, 32'h01f0_707f, 32'h0000_707f};
   localparam InstrT DefDecMatch [DefNoUnits] = '{32'h0000_3077, 32'h0000_1077, 32'h0000_0077, 32'h0000_2077};

   function automatic logic dec_hit(input InstrT instr, input dec_row_t row);
      return (instr & row.mask) == row.match;
   endfunction

endpackage

// File: rtl/xadac_rr_lock_arb.sv
// Round-robin arbiter whose grant is frozen while a granted request waits on i_ready.
// Zero-latency grant; holds the same grant until its handshake, then rotates past it.
module xadac_rr_lock_arb #(
   parameter int unsigned NoReq = 4,
   localparam int unsigned IdxW = (NoReq > 1) ? $clog2(NoReq) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NoReq-1:0]  i_req,
   input  logic              i_ready,
   output logic [IdxW-1:0]   o_grant_idx,
   output logic [NoReq-1:0]  o_grant_oh,
   output logic              o_valid
);

   logic [IdxW-1:0] r_ptr;
   logic [IdxW-1:0] r_grant;
   logic            r_locked;
   logic [IdxW-1:0] w_search;
   logic            w_found;

   function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NoReq) s = s - NoReq;
      return IdxW'(s);
   endfunction

   always_comb begin
      w_search = r_ptr;
      w_found  = 1'b0;
      for (int unsigned k = 0; k < NoReq; k++) begin
         if (!w_found && i_req[wrap_add(r_ptr, k)]) begin
            w_search = wrap_add(r_ptr, k);
            w_found  = 1'b1;
         end
      end
   end

   assign o_grant_idx = r_locked ? r_grant : w_search;
   assign o_valid     = i_req[o_grant_idx];
   assign o_grant_oh  = o_valid ? (NoReq'(1) << o_grant_idx) : '0;

   // A locked requester that drops valid simply releases the lock; the pointer stays put.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ptr    <= '0;
         r_grant  <= '0;
         r_locked <= 1'b0;
      end else if (o_valid && !i_ready) begin
         r_locked <= 1'b1;
         r_grant  <= o_grant_idx;
      end else begin
         r_locked <= 1'b0;
         if (o_valid)
            r_ptr <= (o_grant_idx == IdxW'(NoReq - 1)) ? '0 : o_grant_idx + IdxW'(1);
      end
   end

endmodule

// File: rtl/xadac_ex_dispatch.sv
// Routes offloaded ops to functional units by mask/match decode with per-unit credit limits.
// Request path is combinational; full units stall the core, responses merge via a lock-stable RR arbiter.
module xadac_ex_dispatch
   import xadac_pkg::*;
#(
   parameter int unsigned NoUnits        = 4,
   parameter int unsigned MaxOutstanding = 2,
   parameter InstrT       DecMask  [NoUnits] = DefDecMask,
   parameter InstrT       DecMatch [NoUnits] = DefDecMatch
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      slv_req_valid,
   output logic                      slv_req_ready,
   input  ex_req_t                   slv_req,
   output ex_info_t                  slv_req_info,
   output logic     [NoUnits-1:0]    unit_req_valid,
   input  logic     [NoUnits-1:0]    unit_req_ready,
   output ex_req_t                   unit_req,
   input  ex_info_t [NoUnits-1:0]    unit_req_info,
   input  logic     [NoUnits-1:0]    unit_resp_valid,
   output logic     [NoUnits-1:0]    unit_resp_ready,
   input  ex_resp_t [NoUnits-1:0]    unit_resp,
   output logic                      slv_resp_valid,
   input  logic                      slv_resp_ready,
   output ex_resp_t                  slv_resp,
   output logic                      busy,
   output logic                      resp_underflow
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned SelW = (NoUnits > 1) ? $clog2(NoUnits) : 1;

   if (NoUnits < 2) begin : g_chk_units
      $error("xadac_ex_dispatch: NoUnits must be at least 2");
   end
   if (MaxOutstanding < 1) begin : g_chk_outstanding
      $error("xadac_ex_dispatch: MaxOutstanding must be at least 1");
   end
   if ($size(DecMask) != NoUnits || $size(DecMatch) != NoUnits) begin : g_chk_table
      $error("xadac_ex_dispatch: decode table length differs from NoUnits");
   end

   logic [CntW-1:0]    r_cnt [NoUnits];
   logic [NoUnits-1:0] w_hit;
   logic [NoUnits-1:0] w_full;
   logic [NoUnits-1:0] w_zero;
   logic [NoUnits-1:0] w_inc;
   logic [NoUnits-1:0] w_dec;
   logic [SelW-1:0]    w_sel;
   logic               w_any_hit;
   logic [SelW-1:0]    w_gnt_idx;
   logic [NoUnits-1:0] w_gnt_oh;

   for (genvar i = 0; i < NoUnits; i++) begin : g_unit
      assign w_hit[i]  = dec_hit(slv_req.instr, dec_row_t'{mask: DecMask[i], match: DecMatch[i]});
      assign w_full[i] = (r_cnt[i] == CntW'(MaxOutstanding));
      assign w_zero[i] = (r_cnt[i] == '0);
      assign w_inc[i]  = unit_req_valid[i] & unit_req_ready[i] & unit_req_info[i].accept;
      assign w_dec[i]  = unit_resp_valid[i] & unit_resp_ready[i];
   end

   // Descending scan so the lowest-index hit wins.
   always_comb begin
      w_sel     = '0;
      w_any_hit = 1'b0;
      for (int i = NoUnits - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_sel     = SelW'(i);
            w_any_hit = 1'b1;
         end
      end
   end

   // Undecodable ops are consumed at once with accept=0 so the core can trap them.
   always_comb begin
      unit_req_valid = '0;
      slv_req_ready  = 1'b0;
      slv_req_info   = '0;
      if (slv_req_valid) begin
         if (!w_any_hit) begin
            slv_req_ready = 1'b1;
         end else begin
            unit_req_valid[w_sel] = ~w_full[w_sel];
            slv_req_ready         = unit_req_ready[w_sel] & ~w_full[w_sel];
            slv_req_info          = unit_req_info[w_sel];
         end
      end
   end

   assign unit_req = slv_req;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NoUnits; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NoUnits; i++) begin
            if (w_inc[i] && !w_dec[i])
               r_cnt[i] <= r_cnt[i] + CntW'(1);
            else if (w_dec[i] && !w_inc[i] && !w_zero[i])
               r_cnt[i] <= r_cnt[i] - CntW'(1);
         end
      end
   end

   assign busy           = |(~w_zero);
   assign resp_underflow = |(w_dec & w_zero);

   xadac_rr_lock_arb #(.NoReq(NoUnits)) u_resp_arb (
      .clk         (clk),
      .rstn        (rstn),
      .i_req       (unit_resp_valid),
      .i_ready     (slv_resp_ready),
      .o_grant_idx (w_gnt_idx),
      .o_grant_oh  (w_gnt_oh),
      .o_valid     (slv_resp_valid)
   );

   assign slv_resp        = unit_resp[w_gnt_idx];
   assign unit_resp_ready = w_gnt_oh & {NoUnits{slv_resp_ready}};

endmodule

// File: tb/tb_xadac_ex_dispatch.sv
// Self-checking bench for xadac_ex_dispatch: directed scenarios then a randomized run against a reference model.
module tb_xadac_ex_dispatch;
   import xadac_pkg::*;

   localparam int N    = 4;
   localparam int MAXO = 2;
   localparam InstrT MASK  [N] = '{32'h0000_707f, 32'h01f0_707f, 32'h01f0_707f, 32'h0000_707f};
   localparam InstrT MATCH [N] = '{32'h0000_3077, 32'h0000_1077, 32'h0000_0077, 32'h0000_2077};
   localparam InstrT INS   [N] = '{32'h0000_3077, 32'h0000_1077, 32'h0000_0077, 32'h0000_2077};

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic                slv_req_valid;
   logic                slv_req_ready;
   ex_req_t             slv_req;
   ex_info_t            slv_req_info;
   logic     [N-1:0]    unit_req_valid;
   logic     [N-1:0]    unit_req_ready;
   ex_req_t             unit_req;
   ex_info_t [N-1:0]    unit_req_info;
   logic     [N-1:0]    unit_resp_valid;
   logic     [N-1:0]    unit_resp_ready;
   ex_resp_t [N-1:0]    unit_resp;
   logic                slv_resp_valid;
   logic                slv_resp_ready;
   ex_resp_t            slv_resp;
   logic                busy;
   logic                resp_underflow;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   xadac_ex_dispatch #(.NoUnits(N), .MaxOutstanding(MAXO), .DecMask(MASK), .DecMatch(MATCH)) dut (
      .clk(clk), .rstn(rstn),
      .slv_req_valid(slv_req_valid), .slv_req_ready(slv_req_ready), .slv_req(slv_req), .slv_req_info(slv_req_info),
      .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready), .unit_req(unit_req), .unit_req_info(unit_req_info),
      .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready), .unit_resp(unit_resp),
      .slv_resp_valid(slv_resp_valid), .slv_resp_ready(slv_resp_ready), .slv_resp(slv_resp),
      .busy(busy), .resp_underflow(resp_underflow)
   );

   task automatic idle();
      slv_req_valid   = 1'b0;
      slv_req         = '0;
      unit_req_ready  = '0;
      unit_req_info   = '0;
      unit_resp_valid = '0;
      unit_resp       = '0;
      slv_resp_ready  = 1'b0;
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   function automatic ex_resp_t rand_resp();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[$bits(ex_resp_t)-1:0];
   endfunction

   task automatic put_req(input InstrT instr, input logic [N-1:0] rdy);
      slv_req_valid  = 1'b1;
      slv_req.id     = 4'($urandom);
      slv_req.instr  = instr;
      slv_req.rs1    = $urandom;
      slv_req.vs2    = {$urandom, $urandom};
      unit_req_ready = rdy;
      for (int u = 0; u < N; u++) unit_req_info[u] = ex_info_t'({7'($urandom), 1'b1});
   endtask

   task automatic dispatch(input int u);
      next(); idle();
      put_req(INS[u], 4'(1 << u));
   endtask

   task automatic test_reset();
      idle();
      rstn = 1'b0;
      #12;
      n_checks++; if ({unit_req_valid, slv_req_ready, slv_req_info} !== '0) $display("FAIL reset_req_outputs got=%h exp=0", {unit_req_valid, slv_req_ready, slv_req_info}); else n_pass++;
      n_checks++; if ({slv_resp_valid, unit_resp_ready, slv_resp} !== '0) $display("FAIL reset_resp_outputs got=%h exp=0", {slv_resp_valid, unit_resp_ready, slv_resp}); else n_pass++;
      n_checks++; if ({busy, resp_underflow} !== 2'b00) $display("FAIL reset_busy_uf got=%b exp=00", {busy, resp_underflow}); else n_pass++;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_checks++; if ({busy, unit_req_valid, slv_resp_valid} !== '0) $display("FAIL reset_release got=%h exp=0", {busy, unit_req_valid, slv_resp_valid}); else n_pass++;
   endtask

   task automatic test_dispatch();
      ex_resp_t r;
      next(); idle();
      put_req(32'h0000_3077, 4'b0001);
      unit_req_info[0] = 8'hA5;
      unit_req_info[1] = 8'hFF;
      #1;
      n_checks++; if (unit_req_valid !== 4'b0001) $display("FAIL disp_uvalid got=%b exp=0001", unit_req_valid); else n_pass++;
      n_checks++; if (slv_req_ready !== 1'b1) $display("FAIL disp_ready got=%b exp=1", slv_req_ready); else n_pass++;
      n_checks++; if (slv_req_info !== 8'hA5) $display("FAIL disp_info got=%h exp=a5", slv_req_info); else n_pass++;
      n_checks++; if (unit_req !== slv_req) $display("FAIL disp_payload got=%h exp=%h", unit_req, slv_req); else n_pass++;
      next(); idle(); #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL disp_busy got=%b exp=1", busy); else n_pass++;
      n_checks++; if (slv_req_info !== '0) $display("FAIL disp_info_idle got=%h exp=0", slv_req_info); else n_pass++;
      r = rand_resp();
      next(); idle();
      unit_resp_valid = 4'b0001; unit_resp[0] = r; slv_resp_ready = 1'b1;
      #1;
      n_checks++; if (unit_resp_ready !== 4'b0001) $display("FAIL disp_resp_rdy got=%b exp=0001", unit_resp_ready); else n_pass++;
      n_checks++; if (slv_resp_valid !== 1'b1 || slv_resp !== r) $display("FAIL disp_resp got=%b/%h exp=1/%h", slv_resp_valid, slv_resp, r); else n_pass++;
      n_checks++; if (resp_underflow !== 1'b0) $display("FAIL disp_uf got=%b exp=0", resp_underflow); else n_pass++;
      next(); idle(); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL disp_busy_drain got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_no_hit();
      next(); idle();
      put_req(32'h0000_0033, 4'b1111);
      for (int u = 0; u < N; u++) unit_req_info[u] = 8'hFF;
      #1;
      n_checks++; if (unit_req_valid !== 4'b0000) $display("FAIL nohit_uvalid got=%b exp=0000", unit_req_valid); else n_pass++;
      n_checks++; if (slv_req_ready !== 1'b1) $display("FAIL nohit_ready got=%b exp=1", slv_req_ready); else n_pass++;
      n_checks++; if (slv_req_info !== '0) $display("FAIL nohit_info got=%h exp=0", slv_req_info); else n_pass++;
      next(); idle(); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL nohit_busy got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         next(); idle(); put_req(INS[3], 4'b1000); #1;
         n_checks++; if (unit_req_valid !== 4'b1000 || slv_req_ready !== 1'b1) $display("FAIL b2b_op%0d got=%b/%b exp=1000/1", k, unit_req_valid, slv_req_ready); else n_pass++;
      end
      next(); idle(); put_req(INS[3], 4'b1000); #1;
      n_checks++; if (unit_req_valid !== 4'b0000 || slv_req_ready !== 1'b0) $display("FAIL b2b_full got=%b/%b exp=0000/0", unit_req_valid, slv_req_ready); else n_pass++;
      next(); idle(); put_req(INS[3], 4'b1000);
      unit_resp_valid = 4'b1000; unit_resp[3] = rand_resp(); slv_resp_ready = 1'b1; #1;
      n_checks++; if (unit_req_valid !== 4'b0000) $display("FAIL b2b_full_during_resp got=%b exp=0000", unit_req_valid); else n_pass++;
      n_checks++; if (unit_resp_ready !== 4'b1000) $display("FAIL b2b_resp_rdy got=%b exp=1000", unit_resp_ready); else n_pass++;
      next(); idle(); put_req(INS[3], 4'b1000); #1;
      n_checks++; if (unit_req_valid !== 4'b1000 || slv_req_ready !== 1'b1) $display("FAIL b2b_op3 got=%b/%b exp=1000/1", unit_req_valid, slv_req_ready); else n_pass++;
      next(); idle(); put_req(INS[3], 4'b1000); #1;
      n_checks++; if (unit_req_valid !== 4'b0000) $display("FAIL b2b_refull got=%b exp=0000", unit_req_valid); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         next(); idle(); unit_resp_valid = 4'b1000; unit_resp[3] = rand_resp(); slv_resp_ready = 1'b1;
      end
      next(); idle(); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_round_robin();
      ex_resp_t rr [N];
      for (int u = 0; u < N; u++) rr[u] = rand_resp();
      for (int u = 1; u < N; u++) dispatch(u);
      for (int k = 1; k < N; k++) begin
         next(); idle();
         unit_resp_valid = 4'b1110; for (int u = 0; u < N; u++) unit_resp[u] = rr[u]; slv_resp_ready = 1'b1; #1;
         n_checks++; if (unit_resp_ready !== 4'(1 << k) || slv_resp !== rr[k]) $display("FAIL rr_grant%0d got=%b/%h exp=%b/%h", k, unit_resp_ready, slv_resp, 4'(1 << k), rr[k]); else n_pass++;
         n_checks++; if (resp_underflow !== 1'b0) $display("FAIL rr_uf%0d got=%b exp=0", k, resp_underflow); else n_pass++;
      end
      next(); idle();
      unit_resp_valid = 4'b1010; for (int u = 0; u < N; u++) unit_resp[u] = rr[u]; #1;
      n_checks++; if (slv_resp_valid !== 1'b1 || slv_resp !== rr[1]) $display("FAIL rr_wrap got=%b/%h exp=1/%h", slv_resp_valid, slv_resp, rr[1]); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rr_busy got=%b exp=0", busy); else n_pass++;
      next(); idle(); #1;
      next(); idle(); unit_resp_valid = 4'b1000; unit_resp[3] = rr[3]; #1;
      n_checks++; if (slv_resp_valid !== 1'b1 || slv_resp !== rr[3]) $display("FAIL rr_lock_release got=%b/%h exp=1/%h", slv_resp_valid, slv_resp, rr[3]); else n_pass++;
      next(); idle();
   endtask

   task automatic test_lock();
      ex_resp_t r0, r2;
      r0 = rand_resp(); r2 = rand_resp();
      dispatch(2); dispatch(0);
      for (int c = 1; c <= 4; c++) begin
         next(); idle();
         unit_resp_valid = (c == 1) ? 4'b0100 : 4'b0101;
         unit_resp[0] = r0; unit_resp[2] = r2; slv_resp_ready = (c == 4); #1;
         n_checks++; if (slv_resp_valid !== 1'b1 || slv_resp !== r2) $display("FAIL lock_c%0d got=%b/%h exp=1/%h", c, slv_resp_valid, slv_resp, r2); else n_pass++;
         n_checks++; if (unit_resp_ready !== ((c == 4) ? 4'b0100 : 4'b0000)) $display("FAIL lock_rdy_c%0d got=%b", c, unit_resp_ready); else n_pass++;
      end
      next(); idle();
      unit_resp_valid = 4'b0001; unit_resp[0] = r0; slv_resp_ready = 1'b1; #1;
      n_checks++; if (unit_resp_ready !== 4'b0001 || slv_resp !== r0) $display("FAIL lock_after got=%b/%h exp=0001/%h", unit_resp_ready, slv_resp, r0); else n_pass++;
      next(); idle(); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL lock_busy got=%b exp=0", busy); else n_pass++;
   endtask

   task automatic test_reset_mid();
      ex_resp_t r0, r3;
      r0 = rand_resp(); r3 = rand_resp();
      dispatch(0); dispatch(3); dispatch(3);
      next(); idle();
      unit_resp_valid = 4'b1001; unit_resp[0] = r0; unit_resp[3] = r3; #1;
      n_checks++; if (slv_resp !== r3 || busy !== 1'b1) $display("FAIL rmid_pre got=%h/%b exp=%h/1", slv_resp, busy, r3); else n_pass++;
      next();
      #2; rstn = 1'b0; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (slv_resp_valid !== 1'b1 || slv_resp !== r0) $display("FAIL rmid_grant got=%b/%h exp=1/%h", slv_resp_valid, slv_resp, r0); else n_pass++;
      #1; rstn = 1'b1;
      next(); #1;
      n_checks++; if (slv_resp !== r0 || busy !== 1'b0) $display("FAIL rmid_post got=%h/%b exp=%h/0", slv_resp, busy, r0); else n_pass++;
      next(); idle();
   endtask

   task automatic test_underflow();
      next(); idle();
      unit_resp_valid = 4'b0010; unit_resp[1] = rand_resp(); slv_resp_ready = 1'b1; #1;
      n_checks++; if (resp_underflow !== 1'b1 || unit_resp_ready !== 4'b0010) $display("FAIL uf_flag got=%b/%b exp=1/0010", resp_underflow, unit_resp_ready); else n_pass++;
      next(); idle(); #1;
      n_checks++; if (resp_underflow !== 1'b0 || busy !== 1'b0) $display("FAIL uf_after got=%b/%b exp=0/0", resp_underflow, busy); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         next(); idle(); put_req(INS[1], 4'b0010); #1;
         n_checks++; if (slv_req_ready !== (k < 2)) $display("FAIL uf_credit%0d got=%b exp=%b", k, slv_req_ready, (k < 2)); else n_pass++;
      end
      for (int k = 0; k < 2; k++) begin
         next(); idle(); unit_resp_valid = 4'b0010; unit_resp[1] = rand_resp(); slv_resp_ready = 1'b1; #1;
         n_checks++; if (resp_underflow !== 1'b0) $display("FAIL uf_drain%0d got=%b exp=0", k, resp_underflow); else n_pass++;
      end
      next(); idle();
   endtask

   task automatic test_random();
      int m_cnt [N];
      int m_ptr, m_grant, pick, sel, g;
      bit m_lock, acc, hs, e_rdy, e_rv, e_busy, e_uf;
      logic [N-1:0] e_uv, e_urr;
      ex_info_t e_info;
      InstrT base;
      next(); idle(); rstn = 1'b0; #1; rstn = 1'b1;
      for (int u = 0; u < N; u++) m_cnt[u] = 0;
      m_ptr = 0; m_grant = 0; m_lock = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         next();
         slv_req_valid = ($urandom_range(0, 3) != 0);
         pick = $urandom_range(0, 5);
         base = (pick < 4) ? INS[pick] : (pick == 4) ? 32'h0000_0033 : $urandom;
         slv_req.id = 4'($urandom); slv_req.rs1 = $urandom; slv_req.rs2 = $urandom;
         slv_req.vs1 = {$urandom, $urandom}; slv_req.vs2 = {$urandom, $urandom}; slv_req.vs3 = {$urandom, $urandom};
         slv_req.instr = (pick < 5) ? (base | ($urandom & 32'hfe00_0f80)) : base;
         unit_req_ready = 4'($urandom);
         for (int u = 0; u < N; u++) begin
            unit_req_info[u]   = 8'($urandom);
            unit_resp[u]       = rand_resp();
            unit_resp_valid[u] = (m_cnt[u] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
         end
         if (m_lock && $urandom_range(0, 7) != 0) unit_resp_valid[m_grant] = 1'b1;
         slv_resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         sel = -1;
         for (int u = 0; u < N; u++) if (sel < 0 && (slv_req.instr & MASK[u]) == MATCH[u]) sel = u;
         e_uv = '0; e_rdy = 0; e_info = '0;
         if (slv_req_valid) begin
            if (sel < 0) e_rdy = 1;
            else begin
               e_uv[sel] = (m_cnt[sel] < MAXO);
               e_rdy     = (m_cnt[sel] < MAXO) && unit_req_ready[sel];
               e_info    = unit_req_info[sel];
            end
         end
         g = -1;
         if (m_lock) g = m_grant;
         else for (int k = 0; k < N; k++) if (g < 0 && unit_resp_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         e_rv   = (g >= 0) && unit_resp_valid[g];
         hs     = e_rv && slv_resp_ready;
         e_urr  = hs ? 4'(1 << g) : 4'b0000;
         e_busy = 0;
         for (int u = 0; u < N; u++) if (m_cnt[u] != 0) e_busy = 1;
         e_uf   = hs && (m_cnt[g] == 0);
         n_checks++; if (unit_req_valid !== e_uv) $display("FAIL rnd_uvalid cyc=%0d got=%b exp=%b", cyc, unit_req_valid, e_uv); else n_pass++;
         n_checks++; if (slv_req_ready !== e_rdy) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, slv_req_ready, e_rdy); else n_pass++;
         n_checks++; if (slv_req_info !== e_info) $display("FAIL rnd_info cyc=%0d got=%h exp=%h", cyc, slv_req_info, e_info); else n_pass++;
         n_checks++; if (unit_req !== slv_req) $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, unit_req, slv_req); else n_pass++;
         n_checks++; if (slv_resp_valid !== e_rv) $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, slv_resp_valid, e_rv); else n_pass++;
         if (e_rv) begin
            n_checks++; if (slv_resp !== unit_resp[g]) $display("FAIL rnd_resp cyc=%0d got=%h exp=%h", cyc, slv_resp, unit_resp[g]); else n_pass++;
         end
         n_checks++; if (unit_resp_ready !== e_urr) $display("FAIL rnd_resp_rdy cyc=%0d got=%b exp=%b", cyc, unit_resp_ready, e_urr); else n_pass++;
         n_checks++; if (busy !== e_busy) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); else n_pass++;
         n_checks++; if (resp_underflow !== e_uf) $display("FAIL rnd_uf cyc=%0d got=%b exp=%b", cyc, resp_underflow, e_uf); else n_pass++;
         acc = (sel >= 0) && e_uv[sel] && unit_req_ready[sel] && unit_req_info[sel].accept;
         if (acc && !(hs && g == sel)) m_cnt[sel]++;
         if (hs && !(acc && g == sel) && m_cnt[g] > 0) m_cnt[g]--;
         if (e_rv && !slv_resp_ready) begin
            m_lock = 1; m_grant = g;
         end else begin
            m_lock = 0;
            if (hs) m_ptr = (g + 1) % N;
         end
      end
      next(); idle();
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_no_hit();
      test_back_to_back();
      test_round_robin();
      test_lock();
      test_reset_mid();
      test_underflow();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
